// File: rtl/ksa_param.sv
// ---------------------------------------------------------------------------
// ksa_param -- parametrised RC4 key-scheduling engine
//
// Runs the RC4 key-scheduling swap loop over an external single-port S-box
// RAM with 1-cycle synchronous read latency. Each index takes four cycles:
// read S[i], read S[j'], write S[j'] <= S[i], write S[i] <= S[j'].
//
// Build option: macro KSA_INIT_PASS_EN
//   defined   : an N-cycle INIT pass writes S[k] = k before the swap loop.
//   undefined : the swap loop runs directly on the preloaded RAM contents.
//
// Parameters:
//   ADDR_W    S-box index/data width, depth N = 2**ADDR_W (arithmetic mod N)
//   KEY_BYTES key length in bytes, byte 0 is the most significant byte
//
// Ports:
//   clk     clock, all state on the rising edge
//   rst     synchronous active-high reset
//   en      start request, sampled only while rdy = 1
//   rdy     idle and able to accept en
//   done    one-cycle pulse on the final swap write
//   key     key, latched when the request is accepted
//   addr    S-box address
//   rddata  S-box read data (valid the cycle after a read address)
//   wrdata  S-box write data
//   wren    S-box write enable
// ---------------------------------------------------------------------------
module ksa_param #(
   parameter int ADDR_W    = 8,
   parameter int KEY_BYTES = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   output logic                   rdy,
   output logic                   done,
   input  logic [KEY_BYTES*8-1:0] key,
   output logic [ADDR_W-1:0]      addr,
   input  logic [ADDR_W-1:0]      rddata,
   output logic [ADDR_W-1:0]      wrdata,
   output logic                   wren
);

   localparam int KEY_W  = KEY_BYTES * 8;
   localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam logic [ADDR_W-1:0] I_LAST    = '1;
   localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);

`ifdef KSA_INIT_PASS_EN
   typedef enum logic [2:0] {S_IDLE, S_INIT, S_RD_I, S_LD_I, S_LD_J, S_WR_I} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_RD_I, S_LD_I, S_LD_J, S_WR_I} state_t;
`endif

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   i_q, i_d;
   logic [ADDR_W-1:0]   j_q, j_d;
   logic [KIDX_W-1:0]   kidx_q, kidx_d;
   logic [KEY_W-1:0]    key_q, key_d;
   logic [ADDR_W-1:0]   si_q, si_d;
   logic [ADDR_W-1:0]   sj_q, sj_d;

   // Split the latched key into bytes, byte 0 taken from the MSB end.
   logic [7:0] key_byte [KEY_BYTES];

   genvar gi;
   generate
      for (gi = 0; gi < KEY_BYTES; gi++) begin : g_key_byte
         assign key_byte[gi] = key_q[KEY_W-1-gi*8 -: 8];
      end
   endgenerate

   // Key byte resized to the S-box width, and the candidate new j. jn uses
   // rddata directly, so it is only meaningful in LD_I where rddata = S[i].
   logic [ADDR_W-1:0] kb;
   logic [ADDR_W-1:0] jn;

   always_comb begin
      kb = ADDR_W'(key_byte[kidx_q]);
      jn = j_q + rddata + kb;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         kidx_q  <= '0;
         key_q   <= '0;
         si_q    <= '0;
         sj_q    <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         kidx_q  <= kidx_d;
         key_q   <= key_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      kidx_d  = kidx_q;
      key_d   = key_q;
      si_d    = si_q;
      sj_d    = sj_q;
      case (state_q)
         S_IDLE: begin
            if (en) begin
               key_d  = key;
               i_d    = '0;
               j_d    = '0;
               kidx_d = '0;
`ifdef KSA_INIT_PASS_EN
               state_d = S_INIT;
`else
               state_d = S_RD_I;
`endif
            end
         end
`ifdef KSA_INIT_PASS_EN
         S_INIT: begin
            if (i_q == I_LAST) begin
               i_d     = '0;
               state_d = S_RD_I;
            end else begin
               i_d = i_q + 1'b1;
            end
         end
`endif
         S_RD_I: state_d = S_LD_I;
         S_LD_I: begin
            si_d    = rddata;
            j_d     = jn;
            state_d = S_LD_J;
         end
         S_LD_J: begin
            sj_d    = rddata;
            state_d = S_WR_I;
         end
         S_WR_I: begin
            kidx_d = (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
            if (i_q == I_LAST) begin
               state_d = S_IDLE;
            end else begin
               i_d     = i_q + 1'b1;
               state_d = S_RD_I;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode. The S[j] read is issued in LD_I, before either write of
   // this iteration, so when i == j both writes carry the same old value.
   always_comb begin
      rdy    = 1'b0;
      done   = 1'b0;
      wren   = 1'b0;
      addr   = '0;
      wrdata = '0;
      case (state_q)
         S_IDLE: rdy = 1'b1;
`ifdef KSA_INIT_PASS_EN
         S_INIT: begin
            addr   = i_q;
            wrdata = i_q;
            wren   = 1'b1;
         end
`endif
         S_RD_I: addr = i_q;
         S_LD_I: addr = jn;
         S_LD_J: begin
            addr   = j_q;
            wrdata = si_q;
            wren   = 1'b1;
         end
         S_WR_I: begin
            addr   = i_q;
            wrdata = sj_q;
            wren   = 1'b1;
            done   = (i_q == I_LAST);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ksa_param.sv
// ---------------------------------------------------------------------------
// tb_ksa_param -- self-checking bench for ksa_param
//
// Two instances: a 4-entry S-box with a 1-byte key and a 256-entry S-box
// with a 3-byte key, each with its own behavioural RAM. A plain RC4 KSA
// model produces the expected stream of RAM writes (address, data, whether
// it is the final write of a run) and the final S-box; every cycle the
// outputs are compared against that stream, and run latency and final RAM
// contents are checked per run. Works with or without KSA_INIT_PASS_EN.
// ---------------------------------------------------------------------------
module tb_ksa_param;

`ifdef KSA_INIT_PASS_EN
   localparam bit INIT_ON = 1'b1;
`else
   localparam bit INIT_ON = 1'b0;
`endif
   localparam int NS = 4;
   localparam int NB = 256;

   logic       clk = 1'b0;
   logic       rst;
   logic       en_s, rdy_s, done_s, wren_s;
   logic [7:0] key_s;
   logic [1:0] addr_s, rddata_s, wrdata_s;
   logic       en_b, rdy_b, done_b, wren_b;
   logic [23:0] key_b;
   logic [7:0] addr_b, rddata_b, wrdata_b;

   always #5 clk = ~clk;

   ksa_param #(.ADDR_W(2), .KEY_BYTES(1)) dut_s (
      .clk(clk), .rst(rst), .en(en_s), .rdy(rdy_s), .done(done_s), .key(key_s),
      .addr(addr_s), .rddata(rddata_s), .wrdata(wrdata_s), .wren(wren_s));

   ksa_param #(.ADDR_W(8), .KEY_BYTES(3)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .rdy(rdy_b), .done(done_b), .key(key_b),
      .addr(addr_b), .rddata(rddata_b), .wrdata(wrdata_b), .wren(wren_b));

   // Behavioural S-box RAMs. With the init pass built in, preload a
   // non-identity pattern so the init writes actually matter.
   logic [1:0] mem_s [NS];
   logic [7:0] mem_b [NB];
   bit         preload_s = 1'b0;
   bit         preload_b = 1'b0;

   always @(posedge clk) begin
      if (preload_s) begin
         for (int k = 0; k < NS; k++) mem_s[k] <= INIT_ON ? 2'(k + 1) : 2'(k);
      end else if (wren_s) begin
         mem_s[addr_s] <= wrdata_s;
      end
      rddata_s <= mem_s[addr_s];
      if (preload_b) begin
         for (int k = 0; k < NB; k++) mem_b[k] <= INIT_ON ? 8'(k * 7 + 3) : 8'(k);
      end else if (wren_b) begin
         mem_b[addr_b] <= wrdata_b;
      end
      rddata_b <= mem_b[addr_b];
   end

   typedef struct {int a; int d; bit last;} wr_t;
   wr_t q_s[$];
   wr_t q_b[$];
   int  s_model [NB];
   int  n_pass  = 0;
   int  n_total = 0;
   bit  cmp_en  = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // RC4 key schedule in plain arithmetic. Appends the expected RAM writes
   // to the queue of instance 'which' (0 = small, 1 = big).
   task automatic model(input int which, input int n, input int nkey, input int key,
                        input int iters, input bit fresh);
      int  j, kb, t, b;
      wr_t w;
      if (fresh || INIT_ON) for (int k = 0; k < n; k++) s_model[k] = k;
      if (INIT_ON) begin
         for (int k = 0; k < n; k++) begin
            w.a = k; w.d = k; w.last = 1'b0;
            if (which == 0) q_s.push_back(w); else q_b.push_back(w);
         end
      end
      j = 0;
      for (int i = 0; i < iters; i++) begin
         b  = i % nkey;
         kb = ((key >> (8 * (nkey - 1 - b))) & 255) % n;
         j  = (j + s_model[i] + kb) % n;
         w.a = j; w.d = s_model[i]; w.last = 1'b0;
         if (which == 0) q_s.push_back(w); else q_b.push_back(w);
         w.a = i; w.d = s_model[j]; w.last = (i == n - 1);
         if (which == 0) q_s.push_back(w); else q_b.push_back(w);
         t = s_model[i]; s_model[i] = s_model[j]; s_model[j] = t;
      end
   endtask

   // Per-cycle comparison of both instances against the expected write stream.
   task automatic compare_cycle();
      wr_t w;
      if (!cmp_en) return;
      if (wren_s) begin
         if (q_s.size() == 0) chk("s_unexpected_write", int'(wren_s), 0);
         else begin
            w = q_s.pop_front();
            chk("s_wr_addr", int'(addr_s), w.a);
            chk("s_wr_data", int'(wrdata_s), w.d);
            chk("s_done", int'(done_s), int'(w.last));
         end
      end else chk("s_done_nowrite", int'(done_s), 0);
      if (wren_b) begin
         if (q_b.size() == 0) chk("b_unexpected_write", int'(wren_b), 0);
         else begin
            w = q_b.pop_front();
            chk("b_wr_addr", int'(addr_b), w.a);
            chk("b_wr_data", int'(wrdata_b), w.d);
            chk("b_done", int'(done_b), int'(w.last));
         end
      end else chk("b_done_nowrite", int'(done_b), 0);
   endtask

   task automatic tick();
      @(negedge clk);
      compare_cycle();
   endtask

   // Small instance run; with hold=1, en stays high so a second run with
   // key k2 must start on the single idle cycle after the first completes.
   task automatic run_s(input int k1, input bit hold, input int k2);
      int busy, mism;
      int exp_busy = INIT_ON ? 5 * NS : 4 * NS;
      preload_s = 1'b1; tick(); preload_s = 1'b0;
      model(0, NS, 1, k1, NS, 1'b1);
      if (hold) model(0, NS, 1, k2, NS, 1'b0);
      chk("s_rdy_before", int'(rdy_s), 1);
      key_s = 8'(k1); en_s = 1'b1; tick();
      if (hold) key_s = 8'(k2); else en_s = 1'b0;
      busy = 0;
      while (rdy_s == 1'b0 && busy < 2000) begin busy++; tick(); end
      chk("s_busy", busy, exp_busy);
      if (hold) begin
         tick(); en_s = 1'b0;
         chk("s_rerun_start", int'(rdy_s), 0);
         busy = 0;
         while (rdy_s == 1'b0 && busy < 2000) begin busy++; tick(); end
         chk("s_busy2", busy, exp_busy);
      end
      mism = 0;
      for (int k = 0; k < NS; k++) if (int'(mem_s[k]) != s_model[k]) mism++;
      chk("s_final_S", mism, 0);
      chk("s_queue_empty", q_s.size(), 0);
      $display("run small key=%02h hold=%0d busy=%0d S=%0d,%0d,%0d,%0d", k1, hold, busy,
               mem_s[0], mem_s[1], mem_s[2], mem_s[3]);
   endtask

   // Big instance run; optional en/key pulses mid-run, optional reset abort.
   task automatic run_b(input int k, input bit pulses, input int abort_at);
      int busy, mism;
      int exp_busy = INIT_ON ? 5 * NB : 4 * NB;
      preload_b = 1'b1; tick(); preload_b = 1'b0;
      model(1, NB, 3, k, NB, 1'b1);
      chk("b_rdy_before", int'(rdy_b), 1);
      key_b = 24'(k); en_b = 1'b1; tick(); en_b = 1'b0;
      busy = 0;
      while (rdy_b == 1'b0 && busy < 3000) begin
         busy++;
         if (busy == abort_at) begin
            rst = 1'b1; q_b.delete(); tick(); rst = 1'b0;
            chk("b_abort_rdy", int'(rdy_b), 1);
            chk("b_abort_wren", int'(wren_b), 0);
            chk("b_abort_done", int'(done_b), 0);
            $display("run big key=%06h aborted by reset at busy cycle %0d", k, busy);
            return;
         end
         if (pulses) begin
            en_b = (busy == 5 || busy == 100 || busy == 500);
            if (en_b) key_b = key_b ^ 24'hA5C3F0;
         end
         tick();
      end
      en_b = 1'b0;
      chk("b_busy", busy, exp_busy);
      mism = 0;
      for (int a = 0; a < NB; a++) if (int'(mem_b[a]) != s_model[a]) mism++;
      chk("b_final_S", mism, 0);
      chk("b_queue_empty", q_b.size(), 0);
      $display("run big key=%06h pulses=%0d busy=%0d S0=%02h S1=%02h", k, pulses, busy,
               mem_b[0], mem_b[1]);
   endtask

   initial begin
      int exp_s [NS];
      exp_s = '{0, 2, 3, 1};
      rst = 1'b1; en_s = 1'b0; en_b = 1'b0; key_s = '0; key_b = '0;
      repeat (3) @(negedge clk);
      chk("rst_rdy_s", int'(rdy_s), 1);
      chk("rst_done_s", int'(done_s), 0);
      chk("rst_wren_s", int'(wren_s), 0);
      chk("rst_addr_s", int'(addr_s), 0);
      chk("rst_wrdata_s", int'(wrdata_s), 0);
      chk("rst_rdy_b", int'(rdy_b), 1);
      chk("rst_done_b", int'(done_b), 0);
      chk("rst_wren_b", int'(wren_b), 0);
      chk("rst_addr_b", int'(addr_b), 0);
      chk("rst_wrdata_b", int'(wrdata_b), 0);
      rst = 1'b0;
      cmp_en = 1'b1;

      // Pin the model against hand-worked results.
      model(0, NS, 1, 0, NS, 1'b1);
      for (int k = 0; k < NS; k++) chk("model_small_S", s_model[k], exp_s[k]);
      q_s.delete();
      model(1, NB, 3, 'h4B6579, 1, 1'b1);
      chk("model_big_S0", s_model[0], 'h4B);
      chk("model_big_S4B", s_model['h4B], 0);
      q_b.delete();

      // Small S-box, key 0x00: i == j at i = 0 and 1 (same-address writes).
      run_s('h00, 1'b0, 0);
      for (int k = 0; k < NS; k++) chk("s_S_literal", int'(mem_s[k]), exp_s[k]);
      run_s('h03, 1'b0, 0);
      run_s('h01, 1'b1, 'h02);

      // Big S-box: main key with ignored en/key pulses, zero key, reset abort.
      run_b('h4B6579, 1'b1, 0);
      run_b('h000000, 1'b0, 0);
      run_b('h123456, 1'b0, 300);
      run_b('h123456, 1'b0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
